// File: rtl/dds_pkg.sv
`default_nettype none
//==============================================================================
// Module : dds_pkg
// Quadrant encoding, unity gain and pipeline depth shared by the sine DDS.
// Rev    : 1.0
//==============================================================================
package dds_pkg;

    typedef enum logic [1:0] {
        QUAD_0 = 2'd0,
        QUAD_1 = 2'd1,
        QUAD_2 = 2'd2,
        QUAD_3 = 2'd3
    } quad_e;

    localparam logic [15:0] c_unity_amp    = 16'h8000;
    localparam int          c_pipe_latency = 3;

    // Falling quarters read the quarter-wave table backwards.
    function automatic logic quad_mirrored(input quad_e q);
        return (q == QUAD_1) || (q == QUAD_3);
    endfunction

    function automatic logic quad_negative(input quad_e q);
        return (q == QUAD_2) || (q == QUAD_3);
    endfunction

endpackage
`default_nettype wire

// File: rtl/quarter_sine_rom.sv
`default_nettype none
//==============================================================================
// Module : quarter_sine_rom
// Synchronous quarter-wave sine table; second read port with SINE_DDS_COS_OUT_EN.
// Rev    : 1.0
//==============================================================================
module quarter_sine_rom #(
    parameter int DATA_W = 24,
    parameter int LUT_AW = 8
) (
    input  logic              clk,
    input  logic              en,
    input  logic [LUT_AW-1:0] addr_a,
    output logic [DATA_W-1:0] data_a
`ifdef SINE_DDS_COS_OUT_EN
    ,
    input  logic [LUT_AW-1:0] addr_b,
    output logic [DATA_W-1:0] data_b
`endif
);

    localparam int  c_depth = 2 ** LUT_AW;
    localparam real c_pi    = 3.14159265358979323846;
    localparam real c_peak  = (2.0 ** (DATA_W - 1)) - 1.0;

    logic [DATA_W-1:0] w_rom [c_depth];

    // Half-LSB phase offset keeps every entry strictly positive.
    for (genvar k = 0; k < c_depth; k++) begin : g_rom_entry
        localparam real c_val = c_peak * $sin(2.0 * c_pi * (real'(k) + 0.5) / real'(4 * c_depth));
        assign w_rom[k] = DATA_W'($rtoi(c_val + 0.5));
    end

    always_ff @(posedge clk) begin
        if (en) begin
            data_a <= w_rom[addr_a];
        end
    end

`ifdef SINE_DDS_COS_OUT_EN
    always_ff @(posedge clk) begin
        if (en) begin
            data_b <= w_rom[addr_b];
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/sine_dds_gen.sv
`default_nettype none
//==============================================================================
// Module : sine_dds_gen
// Rate-divided DDS sine source with ready/valid output; cos_out with SINE_DDS_COS_OUT_EN.
// Rev    : 1.0
//==============================================================================
module sine_dds_gen
    import dds_pkg::*;
#(
    parameter int DATA_W  = 24,
    parameter int LUT_AW  = 8,
    parameter int PHASE_W = 32,
    parameter int DIV_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [PHASE_W-1:0] phase_inc,
    input  logic [DIV_W-1:0]   rate_div,
    input  logic [15:0]        amplitude,
    output logic [DATA_W-1:0]  sample_out,
    output logic               sample_valid,
    input  logic               sample_ready
`ifdef SINE_DDS_COS_OUT_EN
    ,
    output logic [DATA_W-1:0]  cos_out
`endif
);

    localparam int c_amp_w = 16;

    logic                      w_stall;
    logic                      w_adv;
    logic                      w_tick;
    logic [DIV_W-1:0]          r_div_cnt;
    logic [PHASE_W-1:0]        r_phase;
    logic [c_pipe_latency-1:0] r_valid;
    quad_e                     w_quad;
    logic [LUT_AW-1:0]         w_addr_raw;
    logic [LUT_AW-1:0]         w_sin_addr;
    logic [c_amp_w-1:0]        w_amp_sat;
    logic [LUT_AW-1:0]         r_s1_sin_addr;
    logic                      r_s1_sin_neg;
    logic [c_amp_w-1:0]        r_s1_amp;
    logic                      r_s2_sin_neg;
    logic [c_amp_w-1:0]        r_s2_amp;
    logic [DATA_W-1:0]         w_sin_rom;

    function automatic logic [DATA_W-1:0] neg_scale(
        input logic [DATA_W-1:0]  rom_word,
        input logic               neg,
        input logic [c_amp_w-1:0] amp
    );
        logic [DATA_W-1:0]         val;
        logic [DATA_W+c_amp_w:0]   prod;
        val  = neg ? -rom_word : rom_word;
        // Operands widened to the full product width so the low bits equal the signed product.
        prod = {{(c_amp_w + 1){val[DATA_W-1]}}, val} * {{(DATA_W + 1){1'b0}}, amp};
        return DATA_W'(prod >> 15);
    endfunction

    assign sample_valid = r_valid[c_pipe_latency-1];
    assign w_stall      = sample_valid & ~sample_ready;
    assign w_adv        = ~w_stall;
    assign w_tick       = enable & w_adv & (r_div_cnt >= rate_div);
    assign w_quad       = quad_e'(r_phase[PHASE_W-1 -: 2]);
    assign w_addr_raw   = r_phase[PHASE_W-3 -: LUT_AW];
    assign w_sin_addr   = quad_mirrored(w_quad) ? ~w_addr_raw : w_addr_raw;
    assign w_amp_sat    = (amplitude > c_unity_amp) ? c_unity_amp : amplitude;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_phase   <= '0;
        end else if (enable && w_adv) begin
            if (w_tick) begin
                r_div_cnt <= '0;
                r_phase   <= r_phase + phase_inc;
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
        end else if (w_adv) begin
            r_valid <= {r_valid[c_pipe_latency-2:0], w_tick};
        end
    end

    always_ff @(posedge clk) begin
        if (w_adv) begin
            if (w_tick) begin
                r_s1_sin_addr <= w_sin_addr;
                r_s1_sin_neg  <= quad_negative(w_quad);
                r_s1_amp      <= w_amp_sat;
            end
            r_s2_sin_neg <= r_s1_sin_neg;
            r_s2_amp     <= r_s1_amp;
        end
    end

`ifdef SINE_DDS_COS_OUT_EN
    // Adding a quarter turn only moves the quadrant; the table address bits are unchanged.
    quad_e             w_cos_quad;
    logic [LUT_AW-1:0] r_s1_cos_addr;
    logic              r_s1_cos_neg;
    logic              r_s2_cos_neg;
    logic [DATA_W-1:0] w_cos_rom;

    assign w_cos_quad = quad_e'(r_phase[PHASE_W-1 -: 2] + 2'd1);

    always_ff @(posedge clk) begin
        if (w_adv) begin
            if (w_tick) begin
                r_s1_cos_addr <= quad_mirrored(w_cos_quad) ? ~w_addr_raw : w_addr_raw;
                r_s1_cos_neg  <= quad_negative(w_cos_quad);
            end
            r_s2_cos_neg <= r_s1_cos_neg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cos_out <= '0;
        end else if (w_adv && r_valid[c_pipe_latency-2]) begin
            cos_out <= neg_scale(w_cos_rom, r_s2_cos_neg, r_s2_amp);
        end
    end
`endif

    quarter_sine_rom #(
        .DATA_W (DATA_W),
        .LUT_AW (LUT_AW)
    ) u_rom (
        .clk    (clk),
        .en     (w_adv),
        .addr_a (r_s1_sin_addr),
        .data_a (w_sin_rom)
`ifdef SINE_DDS_COS_OUT_EN
        ,
        .addr_b (r_s1_cos_addr),
        .data_b (w_cos_rom)
`endif
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            sample_out <= '0;
        end else if (w_adv && r_valid[c_pipe_latency-2]) begin
            sample_out <= neg_scale(w_sin_rom, r_s2_sin_neg, r_s2_amp);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sine_dds_gen.sv
`default_nettype none
//==============================================================================
// Module : tb_sine_dds_gen
// Scoreboard bench for sine_dds_gen (cos_out checked when SINE_DDS_COS_OUT_EN is set).
// Rev    : 1.0
//==============================================================================
module tb_sine_dds_gen;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [31:0] phase_inc;
    logic [15:0] rate_div;
    logic [15:0] amplitude;
    logic [23:0] sample_out;
    logic        sample_valid;
    logic        sample_ready;
`ifdef SINE_DDS_COS_OUT_EN
    logic [23:0] cos_out;
`endif

    int          n_cmp = 0;
    int          n_err = 0;
    logic [23:0] exp_q[$];
    logic [23:0] cos_q[$];
    logic [31:0] m_phase;
    logic [31:0] m_inc;
    logic [15:0] m_amp;
    int          rom_m [256];

    sine_dds_gen #(
        .DATA_W  (24),
        .LUT_AW  (8),
        .PHASE_W (32),
        .DIV_W   (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .phase_inc    (phase_inc),
        .rate_div     (rate_div),
        .amplitude    (amplitude),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready)
`ifdef SINE_DDS_COS_OUT_EN
        ,
        .cos_out      (cos_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [23:0] model(input logic [31:0] ph, input logic [15:0] amp);
        logic [7:0] a;
        longint     v;
        longint     g;
        a = ph[29:22];
        if (ph[30]) a = ~a;
        v = rom_m[a];
        if (ph[31]) v = -v;
        g = (amp > 16'h8000) ? 64'sd32768 : longint'(amp);
        v = (v * g) >>> 15;
        return v[23:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Compares any transfer happening this cycle, then advances to the next negedge.
    task automatic cyc();
        logic [23:0] e;
        if (sample_valid === 1'b1 && sample_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sample_count", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check("sin_sample", 64'(sample_out), 64'(e));
            end
`ifdef SINE_DDS_COS_OUT_EN
            if (cos_q.size() == 0) begin
                check("cos_count", 64'(cos_q.size()), 64'd1);
            end else begin
                e = cos_q.pop_front();
                check("cos_sample", 64'(cos_out), 64'(e));
            end
`endif
        end
        @(negedge clk);
    endtask

    task automatic set_cfg(input logic [31:0] inc, input logic [15:0] amp);
        m_inc     = inc;
        m_amp     = amp;
        phase_inc = inc;
        amplitude = amp;
    endtask

    task automatic push_n(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(model(m_phase, m_amp));
            cos_q.push_back(model(m_phase + 32'h4000_0000, m_amp));
            m_phase = m_phase + m_inc;
        end
    endtask

    task automatic drain_check(input string tag);
        enable = 1'b0;
        repeat (6) cyc();
        check(tag, 64'(exp_q.size()), 64'd0);
        check("idle_valid", 64'(sample_valid), 64'd0);
        exp_q.delete();
        cos_q.delete();
    endtask

    task automatic run_ticks(input int n, input string tag);
        push_n(n);
        enable = 1'b1;
        repeat (n) cyc();
        drain_check(tag);
    endtask

    initial begin
        int          lat;
        int          gap;
        logic [23:0] held;

        for (int k = 0; k < 256; k++) begin
            rom_m[k] = $rtoi(8388607.0 * $sin(2.0 * 3.14159265358979323846 * (real'(k) + 0.5) / 1024.0) + 0.5);
        end

        reset        = 1'b1;
        enable       = 1'b0;
        sample_ready = 1'b1;
        rate_div     = 16'd0;
        m_phase      = 32'd0;
        set_cfg(32'h4000_0000, 16'h8000);
        repeat (4) cyc();
        check("reset_valid", 64'(sample_valid), 64'd0);
        check("reset_out", 64'(sample_out), 64'd0);

        // R0, R255, -R0, -R255 repeating; first sample three cycles after the first tick
        push_n(12);
        enable = 1'b1;
        reset  = 1'b0;
        lat    = 0;
        while (sample_valid !== 1'b1 && lat < 20) begin
            cyc();
            lat++;
        end
        check("first_latency", 64'(lat), 64'd3);
        repeat (9) cyc();
        drain_check("quad_seq_drain");

        set_cfg(32'h0123_4567, 16'h4000);
        run_ticks(8, "half_amp_drain");
        set_cfg(32'h0123_4567, 16'hFFFF);
        run_ticks(8, "clamp_amp_drain");

        // Backpressure mid-stream: output frozen, no sample lost or repeated
        set_cfg(32'h0A3D_70A4, 16'h8000);
        push_n(20);
        enable = 1'b1;
        repeat (6) cyc();
        sample_ready = 1'b0;
        held = sample_out;
        check("stall_entry_valid", 64'(sample_valid), 64'd1);
        repeat (10) begin
            cyc();
            check("stall_hold", 64'(sample_out), 64'(held));
            check("stall_valid", 64'(sample_valid), 64'd1);
        end
        sample_ready = 1'b1;
        repeat (14) cyc();
        drain_check("stall_drain");

        set_cfg(32'h0000_0000, 16'h6000);
        run_ticks(5, "const_drain");

        // Reset with two samples in flight discards them and restarts from phase 0
        set_cfg(32'h4000_0000, 16'h8000);
        enable = 1'b1;
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        check("midreset_valid", 64'(sample_valid), 64'd0);
        check("midreset_out", 64'(sample_out), 64'd0);
        repeat (2) cyc();
        check("midreset_hold_valid", 64'(sample_valid), 64'd0);
        m_phase = 32'd0;
        push_n(8);
        reset = 1'b0;
        repeat (8) cyc();
        drain_check("restart_drain");

        // Divided rate: ticks every rate_div+1 cycles
        rate_div = 16'd4999;
        push_n(2);
        enable = 1'b1;
        lat    = 0;
        while (sample_valid !== 1'b1 && lat < 6000) begin
            cyc();
            lat++;
        end
        check("div_first", 64'(lat), 64'd5002);
        cyc();
        gap = 1;
        while (sample_valid !== 1'b1 && gap < 6000) begin
            cyc();
            gap++;
        end
        check("div_period", 64'(gap), 64'd5000);
        drain_check("div_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
